mult32x32_arbiter: RTL

Two-requester round-robin arbiter and sequencer for one shared `mult32x32_fast` instance. It accepts operand pairs from two independent clients and issues each granted pair to the multiplier with a one-cycle `start` pulse. It then waits for the multiplier's `busy` to fall and returns the 64-bit product to the granted client with a one-cycle done strobe. A watchdog reports an error if the multiplier never completes.

---
 rtl/mult32x32_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mult32x32_arbiter.sv
// mult32x32_arbiter
// Two-client round-robin arbiter and sequencer for one shared mult32x32_fast.
// A granted operand pair is latched onto mult_a/mult_b and issued with a
// one-cycle mult_start. The arbiter then waits for mult_busy to fall and
// returns the 64-bit product to the granted client with a one-cycle done
// strobe. A watchdog aborts the operation with resp_err=1 if the multiplier
// never completes.
//
// Ports:
//   clk                       clock, rising edge
//   reset                     asynchronous active-low reset
//   req0_valid, req1_valid    client requests (operands held while valid)
//   req0_a/b, req1_a/b        32-bit operands per client
//   ack0, ack1                one-cycle pulse: that client's operands latched
//   done0, done1              one-cycle pulse: response valid for that client
//   resp_product              64-bit product (0 on watchdog abort)
//   resp_err                  watchdog abort flag, qualified by doneN
//   arb_busy                  high whenever the FSM is not in IDLE
//   mult_start, mult_a/b      drive the multiplier
//   mult_busy, mult_product   from the multiplier
module mult32x32_arbiter #(
  parameter int unsigned WATCHDOG = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] resp_product,
  output logic        resp_err,
  output logic        arb_busy,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product
);

  localparam logic [7:0] WD_LIMIT = 8'(WATCHDOG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mult_a_q, mult_a_d;
  logic [31:0] mult_b_q, mult_b_d;
  logic        start_q, start_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [63:0] prod_q, prod_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        any_valid_s;
  logic        win1_s;
  logic [7:0]  cnt_inc_s;

  // Round-robin pick: a lone requester wins; on a tie the client that was
  // not granted last time wins.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req1_valid && (!req0_valid || !last_grant_q)) begin
      win1_s = 1'b1;
    end else begin
      win1_s = 1'b0;
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    prod_d       = prod_q;
    err_d        = err_q;
    start_d      = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    cnt_inc_s    = cnt_q + 8'd1;

    case (state_q)
      // The edge ending DONE also samples requests so back-to-back grants
      // lose no cycle.
      S_IDLE, S_DONE: begin
        if (any_valid_s) begin
          grant_d      = win1_s;
          last_grant_d = win1_s;
          if (win1_s) begin
            mult_a_d = req1_a;
            mult_b_d = req1_b;
          end else begin
            mult_a_d = req0_a;
            mult_b_d = req0_b;
          end
          ack0_d  = ~win1_s;
          ack1_d  = win1_s;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_ARM;
      end
      // mult_busy is ignored here: the multiplier raises it only after
      // seeing start.
      S_ARM: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!mult_busy) begin
          prod_d  = mult_product;
          err_d   = 1'b0;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == WD_LIMIT) begin
            prod_d  = 64'd0;
            err_d   = 1'b1;
            done0_d = ~grant_q;
            done1_d = grant_q;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
      mult_a_q     <= 32'd0;
      mult_b_q     <= 32'd0;
      start_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      prod_q       <= 64'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      start_q      <= start_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      prod_q       <= prod_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign resp_product = prod_q;
  assign resp_err     = err_q;
  assign arb_busy     = busy_q;
  assign mult_start   = start_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;

endmodule
